// File: rtl/bcp_pkg.sv
// Shared types and constants for the BCP sequencer and its implication queue.
package bcp_pkg;

  localparam int unsigned ADDR_W    = 12;
  localparam int unsigned OFF_W     = 2;
  localparam int unsigned LIT_VAR_W = ADDR_W - 4;

  // Literal as carried through the implication queue
  typedef struct packed {
    logic [LIT_VAR_W-1:0] var_idx;
    logic                 val;
  } lit_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_LOAD
  } bcp_state_e;

  // Watch-list base address of a literal: {var, value, 3'b000}
  function automatic logic [ADDR_W-1:0] wl_addr(input lit_t l);
    return {l.var_idx, l.val, 3'b000};
  endfunction

endpackage

// File: rtl/bcp_imp_fifo.sv
// Implication queue: power-of-two FIFO with push, pop, flush and occupancy count.
module bcp_imp_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head_c,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full_c  = (count == CNT_W'(DEPTH));
  assign empty_c = (count == '0);
  assign head_c  = mem[rd_ptr];
  assign push_ok = push && !full_c;
  assign pop_ok  = pop && !empty_c;

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally modulo DEPTH; flush drops everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bcp_controller.sv
// BCP sequencer: walks every watch-list segment of a decision literal, then
// replays queued unit implications until the queue drains or a conflict hits.
// Optional BCP_DEDUP_EN: assignment bitmaps drop repeated implications and
// turn contradicting ones into conflicts.
module bcp_controller
  import bcp_pkg::*;
#(
  parameter int unsigned VAR_W  = 8,
  parameter int unsigned NSEG   = 4,
  parameter int unsigned QDEPTH = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              DEC_VALID,
  input  logic [VAR_W-1:0]  DEC_VAR,
  input  logic              DEC_VAL,
  output logic              DEC_READY,
  output logic              EN,
  output logic              VALUE,
  output logic [OFF_W-1:0]  OFFSET,
  output logic [ADDR_W-1:0] ADDR_IN,
  input  logic              FINISH,
  input  logic              CONFLICT,
  input  logic              UNIT_VALID,
  input  logic [VAR_W-1:0]  UNIT_VAR,
  input  logic              UNIT_VAL,
  output logic              BCP_DONE,
  output logic              BCP_CONFLICT,
  output logic              OVERFLOW,
  output logic              BUSY
);

  localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;
  localparam int unsigned LIT_W = $bits(lit_t);

  bcp_state_e       state, next_state;
  lit_t             dec_lit_c, unit_lit_c, head_lit_c, new_lit_c;
  logic [LIT_W-1:0] head_bits_c;
  logic             fifo_full_c, fifo_empty_c;
  logic [CNT_W-1:0] fifo_count;
  logic             push_win_c, dup_drop_c, dup_conf_c, push_req_c, ovf_c;
  logic             abort_c, last_seg_c, accept_c, adv_c, pop_c, push_c, done_pre_c;

  assign dec_lit_c  = lit_t'{var_idx: LIT_VAR_W'(DEC_VAR), val: DEC_VAL};
  assign unit_lit_c = lit_t'{var_idx: LIT_VAR_W'(UNIT_VAR), val: UNIT_VAL};
  assign head_lit_c = lit_t'(head_bits_c);
  assign new_lit_c  = accept_c ? dec_lit_c : head_lit_c;
  assign push_win_c = (state == S_ISSUE) || (state == S_WAIT);
  assign last_seg_c = (OFFSET == OFF_W'(NSEG - 1));

  bcp_imp_fifo #(
    .WIDTH (LIT_W),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RST),
    .push    (push_c),
    .pop     (pop_c),
    .flush   (abort_c),
    .din     (unit_lit_c),
    .head_c  (head_bits_c),
    .full_c  (fifo_full_c),
    .empty_c (fifo_empty_c),
    .count   (fifo_count)
  );

`ifdef BCP_DEDUP_EN
  localparam int unsigned NVAR = 2 ** LIT_VAR_W;

  logic [NVAR-1:0] asg_map;
  logic [NVAR-1:0] val_map;

  // Classify an incoming implication against the current assignment
  always_comb begin
    dup_drop_c = 1'b0;
    dup_conf_c = 1'b0;
    if (UNIT_VALID && push_win_c && asg_map[unit_lit_c.var_idx]) begin
      if (val_map[unit_lit_c.var_idx] == unit_lit_c.val) dup_drop_c = 1'b1;
      else                                               dup_conf_c = 1'b1;
    end
  end

  // Assignment bitmaps live for one propagation; cleared as it ends
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      asg_map <= '0;
      val_map <= '0;
    end else begin
      if (abort_c || (state == S_LOAD && fifo_empty_c)) begin
        asg_map <= '0;
        val_map <= '0;
      end
      if (accept_c || pop_c) begin
        asg_map[new_lit_c.var_idx] <= 1'b1;
        val_map[new_lit_c.var_idx] <= new_lit_c.val;
      end
    end
  end
`else
  assign dup_drop_c = 1'b0;
  assign dup_conf_c = 1'b0;
`endif

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next state and control strobes; any abort source wins over FINISH
  always_comb begin
    next_state = state;
    accept_c   = 1'b0;
    adv_c      = 1'b0;
    pop_c      = 1'b0;
    push_req_c = UNIT_VALID && push_win_c && !dup_drop_c && !dup_conf_c;
    ovf_c      = push_req_c && fifo_full_c;
    abort_c    = (state == S_WAIT && CONFLICT) || ovf_c || dup_conf_c;
    case (state)
      S_IDLE: begin
        if (DEC_VALID) begin
          accept_c   = 1'b1;
          next_state = S_ISSUE;
        end
      end
      S_ISSUE: next_state = S_WAIT;
      S_WAIT: begin
        if (FINISH) begin
          if (last_seg_c) begin
            next_state = S_LOAD;
          end else begin
            adv_c      = 1'b1;
            next_state = S_ISSUE;
          end
        end
      end
      S_LOAD: begin
        if (fifo_empty_c) begin
          next_state = S_IDLE;
        end else begin
          pop_c      = 1'b1;
          next_state = S_ISSUE;
        end
      end
      default: next_state = S_IDLE;
    endcase
    if (abort_c) begin
      next_state = S_IDLE;
      adv_c      = 1'b0;
    end
    push_c     = push_req_c && !fifo_full_c && !abort_c;
    done_pre_c = (state == S_WAIT) && FINISH && last_seg_c && !abort_c &&
                 (fifo_count == '0) && !push_c;
  end

  // Registered outputs and the current-literal registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      DEC_READY    <= 1'b1;
      EN           <= 1'b0;
      BUSY         <= 1'b0;
      BCP_DONE     <= 1'b0;
      BCP_CONFLICT <= 1'b0;
      OVERFLOW     <= 1'b0;
      VALUE        <= 1'b0;
      OFFSET       <= '0;
      ADDR_IN      <= '0;
    end else begin
      DEC_READY    <= (next_state == S_IDLE);
      EN           <= (next_state == S_ISSUE);
      BUSY         <= (next_state != S_IDLE);
      BCP_DONE     <= done_pre_c;
      BCP_CONFLICT <= abort_c;
      if (accept_c)   OVERFLOW <= 1'b0;
      else if (ovf_c) OVERFLOW <= 1'b1;
      if (accept_c || pop_c) begin
        VALUE   <= new_lit_c.val;
        OFFSET  <= '0;
        ADDR_IN <= wl_addr(new_lit_c);
      end else if (adv_c) begin
        OFFSET  <= OFFSET + OFF_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bcp_controller.sv
// Testbench for bcp_controller: a table of propagation scenarios driven through
// an engine/checker responder, with expected EN issues queued in a scoreboard.
module tb_bcp_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dec_valid = 1'b0;
  logic [7:0]  dec_var = '0;
  logic        dec_val = 1'b0;
  logic        dec_ready;
  logic        en;
  logic        value;
  logic [1:0]  offset;
  logic [11:0] addr_in;
  logic        finish = 1'b0;
  logic        conflict = 1'b0;
  logic        unit_valid = 1'b0;
  logic [7:0]  unit_var = '0;
  logic        unit_val = 1'b0;
  logic        bcp_done;
  logic        bcp_conflict;
  logic        overflow;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  bcp_controller dut (
    .CLK          (clk),
    .RST          (rst),
    .DEC_VALID    (dec_valid),
    .DEC_VAR      (dec_var),
    .DEC_VAL      (dec_val),
    .DEC_READY    (dec_ready),
    .EN           (en),
    .VALUE        (value),
    .OFFSET       (offset),
    .ADDR_IN      (addr_in),
    .FINISH       (finish),
    .CONFLICT     (conflict),
    .UNIT_VALID   (unit_valid),
    .UNIT_VAR     (unit_var),
    .UNIT_VAL     (unit_val),
    .BCP_DONE     (bcp_done),
    .BCP_CONFLICT (bcp_conflict),
    .OVERFLOW     (overflow),
    .BUSY         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached (compared %0d)", n_cmp);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]      dvar;
    logic            dval;
    int              nu;
    logic [8:0][8:0] u;
    int              nq;
    int              push_en;
    int              fin_lat;
    int              conf_en;
    int              exp_en;
    logic            exp_done;
    logic            exp_conf;
    logic            exp_ovf;
  } vec_t;

  typedef struct packed {
    logic [11:0] addr;
    logic [1:0]  off;
    logic        val;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];

  function automatic vec_t mkv(input logic [7:0] dv, input logic dl, input int fl,
                               input int ce, input int een, input logic ed,
                               input logic ec, input logic eo);
    vec_t v;
    v.dvar = dv; v.dval = dl; v.nu = 0; v.u = '0; v.nq = 0; v.push_en = 1;
    v.fin_lat = fl; v.conf_en = ce; v.exp_en = een;
    v.exp_done = ed; v.exp_conf = ec; v.exp_ovf = eo;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One full propagation: handshake, engine responses, outcome checks
  task automatic run_txn(input vec_t v, input int id);
    logic [8:0] lit;
    exp_t e;
    int n, en_cnt, cnt, uidx, hs_cyc, fin_cyc, conf_cyc, last_u_cyc, end_cyc;
    logic uact, got_done, got_conf, ovf_seen, ended;
    n = 0; en_cnt = 0; cnt = 0; uidx = 0; fin_cyc = 0; conf_cyc = 0; last_u_cyc = 0;
    end_cyc = 0; uact = 1'b0; got_done = 1'b0; got_conf = 1'b0; ovf_seen = 1'b0; ended = 1'b0;
    for (int l = 0; l <= v.nq; l++) begin
      lit = (l == 0) ? {v.dvar, v.dval} : v.u[l-1];
      for (int s = 0; s < 4; s++) begin
        if (n < v.exp_en) begin
          sb.push_back('{addr: {lit[8:1], lit[0], 3'b000}, off: 2'(s), val: lit[0]});
          n++;
        end
      end
    end
    check($sformatf("v%0d_ready", id), 32'(dec_ready), 32'd1);
    dec_var = v.dvar; dec_val = v.dval; dec_valid = 1'b1;
    hs_cyc = cyc;
    tick();
    dec_valid = 1'b0;
    check($sformatf("v%0d_ovf_clear", id), 32'(overflow), 32'd0);
    for (int c = 0; c < 400; c++) begin
      finish = 1'b0; conflict = 1'b0; unit_valid = 1'b0;
      if (bcp_done || bcp_conflict) begin
        got_done = bcp_done; got_conf = bcp_conflict; ovf_seen = overflow;
        end_cyc = cyc; ended = 1'b1;
        break;
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          finish = 1'b1; fin_cyc = cyc;
          if (en_cnt == v.conf_en) begin conflict = 1'b1; conf_cyc = cyc; end
        end
      end
      if (uact && uidx < v.nu) begin
        unit_valid = 1'b1;
        {unit_var, unit_val} = v.u[uidx];
        uidx++; last_u_cyc = cyc;
      end
      if (en) begin
        en_cnt++;
        if (sb.size() == 0) begin
          check($sformatf("v%0d_extra_en", id), 32'(en_cnt), 32'(v.exp_en));
        end else begin
          e = sb.pop_front();
          check($sformatf("v%0d_addr%0d", id, en_cnt), 32'(addr_in), 32'(e.addr));
          check($sformatf("v%0d_off%0d", id, en_cnt), 32'(offset), 32'(e.off));
          check($sformatf("v%0d_val%0d", id, en_cnt), 32'(value), 32'(e.val));
          if (en_cnt == 1)      check($sformatf("v%0d_en_lat%0d", id, en_cnt), 32'(cyc), 32'(hs_cyc + 1));
          else if (e.off == 0)  check($sformatf("v%0d_en_lat%0d", id, en_cnt), 32'(cyc), 32'(fin_cyc + 2));
          else                  check($sformatf("v%0d_en_lat%0d", id, en_cnt), 32'(cyc), 32'(fin_cyc + 1));
        end
        cnt = v.fin_lat;
        if (en_cnt == v.push_en) uact = 1'b1;
      end
      tick();
    end
    finish = 1'b0; conflict = 1'b0; unit_valid = 1'b0;
    if (!ended) check($sformatf("v%0d_timeout", id), 32'd0, 32'd1);
    check($sformatf("v%0d_done", id), 32'(got_done), 32'(v.exp_done));
    check($sformatf("v%0d_conflict", id), 32'(got_conf), 32'(v.exp_conf));
    check($sformatf("v%0d_overflow", id), 32'(ovf_seen), 32'(v.exp_ovf));
    check($sformatf("v%0d_en_count", id), 32'(en_cnt), 32'(v.exp_en));
    check($sformatf("v%0d_sb_left", id), 32'(sb.size()), 32'd0);
    sb.delete();
    if (got_done) check($sformatf("v%0d_done_lat", id), 32'(end_cyc), 32'(fin_cyc + 1));
    if (got_conf) begin
      if (v.conf_en != 0) check($sformatf("v%0d_conf_lat", id), 32'(end_cyc), 32'(conf_cyc + 1));
      else                check($sformatf("v%0d_conf_lat", id), 32'(end_cyc), 32'(last_u_cyc + 1));
    end
    tick();
    check($sformatf("v%0d_after", id), 32'({busy, dec_ready, bcp_done, bcp_conflict, en, overflow}),
          32'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, v.exp_ovf}));
  endtask

  initial begin
    vec_t v;
    logic [20:0] rexp;
    rexp = '0;
    rexp[18] = 1'b1;

    // Basic walk of all four segments
    v = mkv(8'h05, 1'b1, 3, 0, 4, 1'b1, 1'b0, 1'b0);
    tbl.push_back(v);
    // Two implications replayed after the decision
    v = mkv(8'h33, 1'b0, 3, 0, 12, 1'b1, 1'b0, 1'b0);
    v.u[0] = {8'h10, 1'b0}; v.u[1] = {8'h22, 1'b1}; v.nu = 2; v.nq = 2;
    tbl.push_back(v);
    // CONFLICT with FINISH, three entries queued
    v = mkv(8'h07, 1'b1, 4, 1, 1, 1'b0, 1'b1, 1'b0);
    v.u[0] = {8'h11, 1'b1}; v.u[1] = {8'h12, 1'b0}; v.u[2] = {8'h13, 1'b1}; v.nu = 3;
    tbl.push_back(v);
    // Nine pushes into an eight-deep queue
    v = mkv(8'h09, 1'b0, 12, 0, 1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) v.u[i] = {8'(8'h40 + i), 1'(i)};
    v.nu = 9;
    tbl.push_back(v);
    // Next decision clears OVERFLOW and starts from an empty queue
    v = mkv(8'hA5, 1'b1, 3, 0, 4, 1'b1, 1'b0, 1'b0);
    tbl.push_back(v);
    // Conflict on the third segment
    v = mkv(8'h01, 1'b0, 2, 3, 3, 1'b0, 1'b1, 1'b0);
    tbl.push_back(v);
    // Push coinciding with the final FINISH is replayed
    v = mkv(8'h0C, 1'b1, 1, 0, 8, 1'b1, 1'b0, 1'b0);
    v.u[0] = {8'h0D, 1'b0}; v.nu = 1; v.nq = 1; v.push_en = 4;
    tbl.push_back(v);
`ifdef BCP_DEDUP_EN
    // Repeat of the decision literal is dropped
    v = mkv(8'h05, 1'b1, 3, 0, 4, 1'b1, 1'b0, 1'b0);
    v.u[0] = {8'h05, 1'b1}; v.nu = 1; v.nq = 0;
    tbl.push_back(v);
    // Contradiction of the decision literal aborts
    v = mkv(8'h05, 1'b1, 3, 0, 1, 1'b0, 1'b1, 1'b0);
    v.u[0] = {8'h05, 1'b0}; v.nu = 1; v.nq = 0;
    tbl.push_back(v);
`endif

    tick();
    tick();
    check("reset_state", 32'({en, busy, dec_ready, bcp_done, bcp_conflict, overflow, value, offset, addr_in}),
          32'(rexp));
    rst = 1'b0;
    tick();

    // Stray engine/checker strobes in IDLE must be ignored
    unit_valid = 1'b1; unit_var = 8'h77; unit_val = 1'b1; finish = 1'b1; conflict = 1'b1;
    tick();
    tick();
    unit_valid = 1'b0; finish = 1'b0; conflict = 1'b0;
    tick();
    check("idle_ignore", 32'({busy, dec_ready, en, bcp_done, bcp_conflict}), 32'({1'b0, 1'b1, 3'b000}));
    run_txn(tbl[0], 100);

    foreach (tbl[i]) run_txn(tbl[i], i);

    // Reset in WAIT with queued implications
    dec_var = 8'h44; dec_val = 1'b1; dec_valid = 1'b1;
    tick();
    dec_valid = 1'b0;
    tick();
    unit_valid = 1'b1; unit_var = 8'h50; unit_val = 1'b1;
    tick();
    unit_var = 8'h51; unit_val = 1'b0;
    tick();
    unit_valid = 1'b0;
    check("pre_reset_busy", 32'({busy, addr_in}), 32'({1'b1, 12'h448}));
    rst = 1'b1;
    #1;
    check("async_reset", 32'({en, busy, dec_ready, bcp_done, bcp_conflict, overflow, value, offset, addr_in}),
          32'(rexp));
    tick();
    tick();
    rst = 1'b0;
    tick();
    run_txn(tbl[0], 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
